// File: rtl/pifo_pkg.sv
// Shared types and helpers for the sorted-array PIFO: default widths, slot entry layout,
// per-slot mux select encoding and the rank compare that treats empty slots as +inf.
package pifo_pkg;

  localparam int PIFO_DEPTH = 16;
  localparam int PIFO_RKW   = 12;
  localparam int PIFO_MTW   = 8;
  localparam int PIFO_PTW   = 12;

  // Slots are stored flat with this layout ({valid, rank, meta, payload}, valid at the MSB).
  typedef struct packed {
    logic                valid;
    logic [PIFO_RKW-1:0] rank;
    logic [PIFO_MTW-1:0] meta;
    logic [PIFO_PTW-1:0] payload;
  } pifo_entry_t;

  typedef enum logic [1:0] {
    SEL_HOLD,
    SEL_LO,
    SEL_HI,
    SEL_IN
  } slot_sel_t;

  // a < b, unsigned; an invalid operand compares as +inf.
  function automatic logic rank_lt(input logic a_v, input logic [31:0] a,
                                   input logic b_v, input logic [31:0] b);
    if (!a_v) return 1'b0;
    if (!b_v) return 1'b1;
    return a < b;
  endfunction

endpackage

// File: rtl/pifo_slot.sv
// One register slot of the sorted array: hold, shift up from below, shift down from above,
// or capture the incoming entry, chosen from the local and neighbouring compare bits.
module pifo_slot
  import pifo_pkg::*;
#(
  parameter int EW     = 33,
  parameter bit BOTTOM = 1'b0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          push,
  input  logic          pop,
  input  logic          gt_self,
  input  logic          gt_lo,
  input  logic          gt_hi,
  input  logic [EW-1:0] ent_lo,
  input  logic [EW-1:0] ent_hi,
  input  logic [EW-1:0] ent_in,
  output logic [EW-1:0] ent
);

  slot_sel_t sel;

  // With a pop the head is gone, so slot j is filled as if it were old slot j+1's neighbour.
  always_comb begin
    sel = SEL_HOLD;
    if (push && pop) begin
      if (!gt_hi)                 sel = SEL_HI;
      else if (BOTTOM || !gt_self) sel = SEL_IN;
    end else if (push) begin
      if (gt_self && gt_lo)        sel = SEL_LO;
      else if (gt_self)            sel = SEL_IN;
    end else if (pop) begin
      sel = SEL_HI;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ent <= {1'b0, {(EW-1){1'b1}}};
    end else begin
      case (sel)
        SEL_LO:  ent <= ent_lo;
        SEL_HI:  ent <= ent_hi;
        SEL_IN:  ent <= ent_in;
        default: ent <= ent;
      endcase
    end
  end

endmodule

// File: rtl/pifo_sorted_array.sv
// Register-array PIFO, lowest rank at slot 0, FIFO among equal ranks.
// Optional tail-drop when full is enabled by defining PIFO_TAIL_DROP_EN.
module pifo_sorted_array
  import pifo_pkg::*;
#(
  parameter int DEPTH = PIFO_DEPTH,
  parameter int RKW   = PIFO_RKW,
  parameter int MTW   = PIFO_MTW,
  parameter int PTW   = PIFO_PTW,
  localparam int CNW  = $clog2(DEPTH+1)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_push,
  input  logic [RKW-1:0]     i_push_rank,
  input  logic [MTW+PTW-1:0] i_push_data,
  output logic               o_push_ready,
  input  logic               i_pop,
  output logic               o_pop_valid,
  output logic [RKW-1:0]     o_pop_rank,
  output logic [MTW+PTW-1:0] o_pop_data,
  output logic [CNW-1:0]     o_count,
  output logic               o_full,
  output logic               o_empty,
  output logic               o_drop_valid,
  output logic [RKW-1:0]     o_drop_rank,
  output logic [MTW+PTW-1:0] o_drop_data
);

  localparam int DW = MTW + PTW;
  localparam int EW = 1 + RKW + DW;
  localparam logic [EW-1:0] EMPTY = {1'b0, {(EW-1){1'b1}}};

  logic [DEPTH-1:0][EW-1:0] ent;
  logic [DEPTH-1:0]         gt;
  logic [EW-1:0]            ent_in;
  logic                     push_acc, pop_acc;
  logic [CNW-1:0]           cnt;

  assign ent_in = {1'b1, i_push_rank, i_push_data};

  // gt[i]: new entry sorts strictly before slot i; monotone 0..01..1 since invalid slots sit on top.
  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      gt[i] = rank_lt(1'b1, 32'(i_push_rank), ent[i][EW-1], 32'(ent[i][EW-2 -: RKW]));
  end

`ifdef PIFO_TAIL_DROP_EN
  assign o_push_ready = 1'b1;
`else
  assign o_push_ready = ~o_full | i_pop;
`endif

  assign push_acc = i_push & o_push_ready;
  assign pop_acc  = i_pop & o_pop_valid;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic          lo_gt, hi_gt;
    logic [EW-1:0] lo_ent, hi_ent;
    if (i == 0) begin : g_bot
      assign lo_gt  = 1'b0;
      assign lo_ent = ent_in;
    end else begin : g_mid_lo
      assign lo_gt  = gt[i-1];
      assign lo_ent = ent[i-1];
    end
    if (i == DEPTH-1) begin : g_top
      assign hi_gt  = 1'b1;
      assign hi_ent = EMPTY;
    end else begin : g_mid_hi
      assign hi_gt  = gt[i+1];
      assign hi_ent = ent[i+1];
    end
    pifo_slot #(.EW(EW), .BOTTOM(i == 0)) u_slot (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .push    (push_acc),
      .pop     (pop_acc),
      .gt_self (gt[i]),
      .gt_lo   (lo_gt),
      .gt_hi   (hi_gt),
      .ent_lo  (lo_ent),
      .ent_hi  (hi_ent),
      .ent_in  (ent_in),
      .ent     (ent[i])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)                                    cnt <= '0;
    else if (push_acc && !pop_acc && !o_full)     cnt <= cnt + CNW'(1);
    else if (pop_acc && !push_acc)                cnt <= cnt - CNW'(1);
  end

  assign o_count     = cnt;
  assign o_full      = (cnt == CNW'(DEPTH));
  assign o_empty     = (cnt == '0);
  assign o_pop_valid = ent[0][EW-1];
  assign o_pop_rank  = ent[0][EW-2 -: RKW];
  assign o_pop_data  = ent[0][DW-1:0];

`ifdef PIFO_TAIL_DROP_EN
  logic          drop_v;
  logic [EW-1:0] drop_ent;

  // Full push without pop: the loser is the old tail if the newcomer sorts before it, else the newcomer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      drop_v   <= 1'b0;
      drop_ent <= '0;
    end else begin
      drop_v   <= push_acc & ~pop_acc & o_full;
      drop_ent <= gt[DEPTH-1] ? ent[DEPTH-1] : ent_in;
    end
  end

  assign o_drop_valid = drop_v;
  assign o_drop_rank  = drop_ent[EW-2 -: RKW];
  assign o_drop_data  = drop_ent[DW-1:0];
`else
  assign o_drop_valid = 1'b0;
  assign o_drop_rank  = '0;
  assign o_drop_data  = '0;
`endif

endmodule

// File: tb/tb_pifo_sorted_array.sv
// Self-checking bench for pifo_sorted_array (DEPTH=4) against a (rank, arrival) sorted queue.
module tb_pifo_sorted_array;

  localparam int DEPTH = 4;
  localparam int RKW   = 12;
  localparam int MTW   = 8;
  localparam int PTW   = 12;
  localparam int DW    = MTW + PTW;
  localparam int CNW   = $clog2(DEPTH+1);
`ifdef PIFO_TAIL_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic           i_clk = 1'b0;
  logic           i_rst, i_push, i_pop;
  logic [RKW-1:0] i_push_rank;
  logic [DW-1:0]  i_push_data;
  logic           o_push_ready, o_pop_valid, o_full, o_empty, o_drop_valid;
  logic [RKW-1:0] o_pop_rank, o_drop_rank;
  logic [DW-1:0]  o_pop_data, o_drop_data;
  logic [CNW-1:0] o_count;

  always #5 i_clk = ~i_clk;

  pifo_sorted_array #(.DEPTH(DEPTH), .RKW(RKW), .MTW(MTW), .PTW(PTW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_push(i_push), .i_push_rank(i_push_rank),
    .i_push_data(i_push_data), .o_push_ready(o_push_ready), .i_pop(i_pop),
    .o_pop_valid(o_pop_valid), .o_pop_rank(o_pop_rank), .o_pop_data(o_pop_data),
    .o_count(o_count), .o_full(o_full), .o_empty(o_empty), .o_drop_valid(o_drop_valid),
    .o_drop_rank(o_drop_rank), .o_drop_data(o_drop_data)
  );

  typedef struct {
    logic [RKW-1:0] rank;
    logic [DW-1:0]  data;
  } ent_t;

  ent_t sb[$];
  ent_t drop_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Per-cycle observations and model predictions filled in by drive().
  logic           obs_ready, obs_pv, obs_dv;
  logic [RKW-1:0] obs_rank, obs_drank;
  logic [DW-1:0]  obs_data, obs_ddata;
  logic [CNW-1:0] obs_cnt;
  int             pre_size;
  bit             exp_ready, had_pop;
  ent_t           exp_pop;

  function automatic void sb_insert(input ent_t e);
    int k = sb.size();
    for (int j = 0; j < sb.size(); j++)
      if (sb[j].rank > e.rank) begin
        k = j;
        break;
      end
    sb.insert(k, e);
  endfunction

  // One clock of stimulus: sample head before the edge, advance the model, sample drop after the edge.
  task automatic drive(input logic push, input logic [RKW-1:0] r, input logic [DW-1:0] d,
                       input logic pop);
    ent_t e;
    i_push = push; i_push_rank = r; i_push_data = d; i_pop = pop;
    #1;
    obs_ready = o_push_ready; obs_pv = o_pop_valid; obs_rank = o_pop_rank;
    obs_data = o_pop_data; obs_cnt = o_count;
    pre_size  = sb.size();
    exp_ready = DROP || (pre_size < DEPTH) || pop;
    had_pop   = pop && (pre_size != 0);
    if (had_pop) exp_pop = sb.pop_front();
    if (push && exp_ready) begin
      e.rank = r; e.data = d;
      sb_insert(e);
      if (sb.size() > DEPTH) drop_q.push_back(sb.pop_back());
    end
    @(posedge i_clk); #1;
    obs_dv = o_drop_valid; obs_drank = o_drop_rank; obs_ddata = o_drop_data;
    i_push = 1'b0; i_pop = 1'b0;
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_push = 1'b0; i_pop = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    sb.delete(); drop_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (o_count !== '0 || o_empty !== 1'b1 || o_full !== 1'b0 || o_pop_valid !== 1'b0 ||
        o_drop_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status: cnt=%0d empty=%b full=%b pv=%b dv=%b, want 0 1 0 0 0",
               o_count, o_empty, o_full, o_pop_valid, o_drop_valid);
    end
    n_checks++;
    if (o_pop_rank !== {RKW{1'b1}} || o_pop_data !== {DW{1'b1}}) begin
      n_fail++;
      $display("FAIL reset_slot0: rank=%h data=%h, want all ones", o_pop_rank, o_pop_data);
    end
  endtask

  task automatic test_order();
    logic [RKW-1:0] pr[4];
    logic [DW-1:0]  pd[4];
    logic [RKW-1:0] er[4];
    logic [DW-1:0]  ed[4];
    pr = '{12'd5, 12'd2, 12'd9, 12'd2};
    pd = '{20'hA, 20'hB, 20'hC, 20'hD};
    er = '{12'd2, 12'd2, 12'd5, 12'd9};
    ed = '{20'hB, 20'hD, 20'hA, 20'hC};
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, pr[i], pd[i], 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, '0, 1'b1);
      n_checks++;
      if (obs_pv !== 1'b1 || obs_rank !== er[i] || obs_data !== ed[i]) begin
        n_fail++;
        $display("FAIL order_pop%0d: pv=%b %0d/%h, want 1 %0d/%h", i, obs_pv, obs_rank,
                 obs_data, er[i], ed[i]);
      end
    end
    n_checks++;
    if (o_empty !== 1'b1 || o_count !== '0) begin
      n_fail++;
      $display("FAIL order_empty: empty=%b cnt=%0d, want 1 0", o_empty, o_count);
    end
  endtask

  task automatic test_full_push_pop();
    logic [RKW-1:0] er[4];
    er = '{12'd3, 12'd4, 12'd5, 12'd7};
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, RKW'(2*i+1), DW'(16+i), 1'b0);
`ifndef PIFO_TAIL_DROP_EN
    drive(1'b1, 12'd0, 20'hEE, 1'b0);
    n_checks++;
    if (obs_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_ready: push_ready=%b, want 0", obs_ready);
    end
    n_checks++;
    if (o_count !== CNW'(4) || o_pop_rank !== 12'd1 || o_pop_data !== 20'd16) begin
      n_fail++;
      $display("FAIL full_unchanged: cnt=%0d head=%0d/%h, want 4 1/10", o_count, o_pop_rank,
               o_pop_data);
    end
`endif
    drive(1'b1, 12'd4, 20'h44, 1'b1);
    n_checks++;
    if (obs_ready !== 1'b1 || obs_rank !== 12'd1 || o_count !== CNW'(4) ||
        o_pop_rank !== 12'd3) begin
      n_fail++;
      $display("FAIL pushpop_full: ready=%b popped=%0d cnt=%0d head=%0d, want 1 1 4 3",
               obs_ready, obs_rank, o_count, o_pop_rank);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, '0, 1'b1);
      n_checks++;
      if (!had_pop || obs_rank !== er[i] || obs_data !== exp_pop.data) begin
        n_fail++;
        $display("FAIL pushpop_order%0d: %0d/%h, want %0d/%h", i, obs_rank, obs_data, er[i],
                 exp_pop.data);
      end
    end
  endtask

  task automatic test_pop_empty();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, '0, 1'b1);
      n_checks++;
      if (o_pop_valid !== 1'b0 || o_count !== '0 || o_empty !== 1'b1 ||
          $isunknown({o_pop_rank, o_pop_data, o_push_ready, o_full, o_drop_valid})) begin
        n_fail++;
        $display("FAIL pop_empty%0d: pv=%b cnt=%0d empty=%b rank=%h, want 0 0 1 known", i,
                 o_pop_valid, o_count, o_empty, o_pop_rank);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, RKW'(2*i+1), DW'(i), 1'b0);
    i_rst = 1'b1; i_push = 1'b1; i_push_rank = 12'd2; i_push_data = 20'h22;
    @(posedge i_clk); #1;
    i_rst = 1'b0; i_push = 1'b0;
    sb.delete(); drop_q.delete();
    n_checks++;
    if (o_count !== '0 || o_empty !== 1'b1 || o_pop_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: cnt=%0d empty=%b pv=%b, want 0 1 0", o_count, o_empty,
               o_pop_valid);
    end
    drive(1'b1, 12'd6, 20'h66, 1'b0);
    n_checks++;
    if (o_pop_valid !== 1'b1 || o_pop_rank !== 12'd6 || o_count !== CNW'(1)) begin
      n_fail++;
      $display("FAIL reset_push: pv=%b head=%0d cnt=%0d, want 1 6 1", o_pop_valid, o_pop_rank,
               o_count);
    end
  endtask

`ifdef PIFO_TAIL_DROP_EN
  task automatic test_tail_drop();
    logic [RKW-1:0] er[4];
    er = '{12'd1, 12'd3, 12'd4, 12'd5};
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, RKW'(2*i+1), DW'(i), 1'b0);
    drive(1'b1, 12'd4, 20'h44, 1'b0);
    n_checks++;
    if (obs_ready !== 1'b1 || obs_dv !== 1'b1 || obs_drank !== 12'd7 || obs_ddata !== 20'd3) begin
      n_fail++;
      $display("FAIL drop_tail: ready=%b dv=%b %0d/%h, want 1 1 7/3", obs_ready, obs_dv,
               obs_drank, obs_ddata);
    end
    void'(drop_q.pop_front());
    drive(1'b0, '0, '0, 1'b0);
    n_checks++;
    if (obs_dv !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_pulse: dv=%b, want 0", obs_dv);
    end
    drive(1'b1, 12'd9, 20'h99, 1'b0);
    n_checks++;
    if (obs_dv !== 1'b1 || obs_drank !== 12'd9 || obs_ddata !== 20'h99 ||
        o_count !== CNW'(4)) begin
      n_fail++;
      $display("FAIL drop_incoming: dv=%b %0d/%h cnt=%0d, want 1 9/99 4", obs_dv, obs_drank,
               obs_ddata, o_count);
    end
    void'(drop_q.pop_front());
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, '0, 1'b1);
      n_checks++;
      if (obs_rank !== er[i]) begin
        n_fail++;
        $display("FAIL drop_order%0d: %0d, want %0d", i, obs_rank, er[i]);
      end
    end
  endtask
`endif

  task automatic test_random();
    int   seq = 0;
    ent_t d;
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      drive($urandom_range(0, 99) < 55, RKW'($urandom_range(0, 7)), DW'(seq), $urandom_range(0, 99) < 45);
      seq++;
      n_checks++;
      if (obs_cnt !== CNW'(pre_size) || obs_ready !== exp_ready || obs_pv !== (pre_size != 0)) begin
        n_fail++;
        if (n_fail < 40)
          $display("FAIL rand_status@%0d: cnt=%0d ready=%b pv=%b, want %0d %b %b", c, obs_cnt,
                   obs_ready, obs_pv, pre_size, exp_ready, pre_size != 0);
      end
      if (had_pop) begin
        n_checks++;
        if (obs_rank !== exp_pop.rank || obs_data !== exp_pop.data) begin
          n_fail++;
          if (n_fail < 40)
            $display("FAIL rand_pop@%0d: %0d/%h, want %0d/%h", c, obs_rank, obs_data,
                     exp_pop.rank, exp_pop.data);
        end
      end
      n_checks++;
      if (obs_dv !== (drop_q.size() != 0)) begin
        n_fail++;
        if (n_fail < 40)
          $display("FAIL rand_drop_valid@%0d: %b, want %b", c, obs_dv, drop_q.size() != 0);
        drop_q.delete();
      end else if (obs_dv) begin
        d = drop_q.pop_front();
        if (obs_drank !== d.rank || obs_ddata !== d.data) begin
          n_fail++;
          if (n_fail < 40)
            $display("FAIL rand_drop@%0d: %0d/%h, want %0d/%h", c, obs_drank, obs_ddata,
                     d.rank, d.data);
        end
      end
    end
  endtask

  initial begin
    i_rst = 1'b1; i_push = 1'b0; i_pop = 1'b0; i_push_rank = '0; i_push_data = '0;
    test_reset();
    test_order();
    test_full_push_pop();
    test_pop_empty();
    test_reset_mid();
`ifdef PIFO_TAIL_DROP_EN
    test_tail_drop();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
